// File: rtl/axi_master_tgen.sv
// AXI4 single-burst traffic generator/checker: address-derived write data, read-back compare.
// Build option: define AXI_TGEN_RDATA_CHECK_EN to compare read data and count mismatching beats.
module axi_master_tgen #(
  parameter int          C_AXI_ADDR_WIDTH = 12,
  parameter int          C_AXI_DATA_WIDTH = 128,
  parameter int          STRB_WIDTH       = C_AXI_DATA_WIDTH/8,
  parameter int          ID_WIDTH         = 1,
  parameter logic [31:0] SEED             = 32'hA5A50000
)(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [C_AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]                  cmd_len,
  input  logic [ID_WIDTH-1:0]         cmd_id,
  output logic                        done,
  output logic                        done_err,
  output logic [15:0]                 err_count,
  output logic [ID_WIDTH-1:0]         m_axi_awid,
  output logic [C_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]                  m_axi_awlen,
  output logic [2:0]                  m_axi_awsize,
  output logic [1:0]                  m_axi_awburst,
  output logic                        m_axi_awlock,
  output logic [3:0]                  m_axi_awcache,
  output logic [2:0]                  m_axi_awprot,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [C_AXI_DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0]       m_axi_wstrb,
  output logic                        m_axi_wlast,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  input  logic [ID_WIDTH-1:0]         m_axi_bid,
  input  logic [1:0]                  m_axi_bresp,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,
  output logic [ID_WIDTH-1:0]         m_axi_arid,
  output logic [C_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                  m_axi_arlen,
  output logic [2:0]                  m_axi_arsize,
  output logic [1:0]                  m_axi_arburst,
  output logic                        m_axi_arlock,
  output logic [3:0]                  m_axi_arcache,
  output logic [2:0]                  m_axi_arprot,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  input  logic [ID_WIDTH-1:0]         m_axi_rid,
  input  logic [C_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  input  logic                        m_axi_rlast,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready
);
  localparam int AW  = C_AXI_ADDR_WIDTH;
  localparam int LSB = $clog2(STRB_WIDTH);
  localparam int NW  = C_AXI_DATA_WIDTH/32;

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [7:0]          len_q, len_d, beat_q, beat_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic                awvalid_q, awvalid_d, arvalid_q, arvalid_d;
  logic                wvalid_q, wvalid_d, wlast_q, wlast_d;
  logic                bready_q, bready_d, rready_q, rready_d;
  logic                done_q, done_d, done_err_q, done_err_d;
  logic                cmd_ready_q, cmd_ready_d, err_acc_q, err_acc_d;
  logic [15:0]         err_count_q, err_count_d;
  logic [31:0]         pat;
  logic [C_AXI_DATA_WIDTH-1:0] exp_data;
  logic                data_bad, beat_err, at_len;

  // addr_q is the start address while AW/AR is pending, then tracks the current beat
  assign pat      = SEED ^ 32'(addr_q);
  assign exp_data = {NW{pat}};
  assign at_len   = (beat_q == len_q);

`ifdef AXI_TGEN_RDATA_CHECK_EN
  assign data_bad = (m_axi_rdata != exp_data);
`else
  assign data_bad = 1'b0;
`endif
  assign beat_err = (m_axi_rresp != 2'b00) || (m_axi_rid != id_q) || data_bad;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    beat_d      = beat_q;
    id_d        = id_q;
    awvalid_d   = awvalid_q;
    arvalid_d   = arvalid_q;
    wvalid_d    = wvalid_q;
    wlast_d     = wlast_q;
    bready_d    = bready_q;
    rready_d    = rready_q;
    done_d      = 1'b0;
    done_err_d  = 1'b0;
    cmd_ready_d = cmd_ready_q;
    err_acc_d   = err_acc_q;
    err_count_d = err_count_q;
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        addr_d      = {cmd_addr[AW-1:LSB], LSB'(0)};
        len_d       = cmd_len;
        id_d        = cmd_id;
        beat_d      = 8'd0;
        err_acc_d   = 1'b0;
        cmd_ready_d = 1'b0;
        if (cmd_write) begin
          state_d   = S_AW;
          awvalid_d = 1'b1;
        end else begin
          state_d   = S_AR;
          arvalid_d = 1'b1;
        end
      end
      S_AW: if (m_axi_awready) begin
        awvalid_d = 1'b0;
        wvalid_d  = 1'b1;
        wlast_d   = (len_q == 8'd0);
        state_d   = S_W;
      end
      S_W: if (m_axi_wready) begin
        if (at_len) begin
          wvalid_d = 1'b0;
          wlast_d  = 1'b0;
          bready_d = 1'b1;
          state_d  = S_B;
        end else begin
          beat_d  = beat_q + 8'd1;
          addr_d  = addr_q + AW'(STRB_WIDTH);
          wlast_d = (beat_q + 8'd1 == len_q);
        end
      end
      S_B: if (m_axi_bvalid) begin
        bready_d    = 1'b0;
        done_d      = 1'b1;
        done_err_d  = (m_axi_bresp != 2'b00) || (m_axi_bid != id_q);
        cmd_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
      S_AR: if (m_axi_arready) begin
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
        state_d   = S_R;
      end
      S_R: if (m_axi_rvalid) begin
        if (data_bad && err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
        // an early rlast or a missing one at the final beat both close the burst with an error
        if (m_axi_rlast || at_len) begin
          rready_d    = 1'b0;
          done_d      = 1'b1;
          done_err_d  = err_acc_q || beat_err || (m_axi_rlast != at_len);
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          err_acc_d = err_acc_q || beat_err;
          beat_d    = beat_q + 8'd1;
          addr_d    = addr_q + AW'(STRB_WIDTH);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      id_q        <= '0;
      awvalid_q   <= 1'b0;
      arvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      wlast_q     <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      done_q      <= 1'b0;
      done_err_q  <= 1'b0;
      cmd_ready_q <= 1'b1;
      err_acc_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      id_q        <= id_d;
      awvalid_q   <= awvalid_d;
      arvalid_q   <= arvalid_d;
      wvalid_q    <= wvalid_d;
      wlast_q     <= wlast_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      done_q      <= done_d;
      done_err_q  <= done_err_d;
      cmd_ready_q <= cmd_ready_d;
      err_acc_q   <= err_acc_d;
      err_count_q <= err_count_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign done          = done_q;
  assign done_err      = done_err_q;
  assign err_count     = err_count_q;
  assign m_axi_awid    = id_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = 3'(LSB);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'd0;
  assign m_axi_awprot  = 3'd0;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = exp_data;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = wlast_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_arid    = id_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = 3'(LSB);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'd0;
  assign m_axi_arprot  = 3'd0;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;
endmodule

// File: tb/tb_axi_master_tgen.sv
// Scoreboard bench for axi_master_tgen: a small RAM slave answers bursts, a monitor checks AW/AR/W/done.
module tb_axi_master_tgen;
  localparam int AW = 12, DW = 128, SW = 16, IW = 1, CW = DW + 1;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [AW-1:0] cmd_addr = '0;
  logic [7:0] cmd_len = '0;
  logic [IW-1:0] cmd_id = '0;
  logic done, done_err;
  logic [15:0] err_count;
  logic [IW-1:0] awid, arid, bid = '0, rid = '0;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize, awprot, arprot;
  logic [1:0] awburst, arburst, bresp = '0, rresp = '0;
  logic awlock, arlock;
  logic [3:0] awcache, arcache;
  logic awvalid, awready = 0, wvalid, wready = 0, wlast, bvalid = 0, bready;
  logic arvalid, arready = 0, rvalid = 0, rready, rlast = 0;
  logic [DW-1:0] wdata, rdata = '0;
  logic [SW-1:0] wstrb;

  axi_master_tgen dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id), .done(done), .done_err(done_err),
    .err_count(err_count),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache), .m_axi_awprot(awprot),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
    .m_axi_wready(wready),
    .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache), .m_axi_arprot(arprot),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  typedef struct packed { logic [AW-1:0] addr; logic [7:0] len; logic [IW-1:0] id; } ax_t;
  typedef struct packed { logic [DW-1:0] data; logic last; } w_t;
  typedef struct packed { logic err; logic [15:0] cnt; } d_t;

  ax_t exp_aw[$], exp_ar[$], ma;
  w_t  exp_w[$], mw;
  d_t  exp_d[$], md;
  logic [DW-1:0] mem [256];
  int n_chk = 0, n_pass = 0;
  logic [15:0] ecnt = 16'd0;

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_chk++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {4{32'hA5A50000 ^ {20'h0, a}}};
  endfunction

  task automatic push_w(input logic [AW-1:0] a, input int len);
    for (int k = 0; k <= len; k++) exp_w.push_back('{pat(a + AW'(k*SW)), k == len});
  endtask

  // monitor: compares every handshake and done pulse against the queues
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (awvalid && awready) begin
        if (exp_aw.size() == 0) fail("aw unexpected");
        else begin
          ma = exp_aw.pop_front();
          chk("aw fields", CW'({awaddr, awlen, awid, awsize, awburst, awlock, awcache, awprot}),
              CW'({ma.addr, ma.len, ma.id, 3'd4, 2'b01, 1'b0, 4'd0, 3'd0}));
        end
      end
      if (arvalid && arready) begin
        if (exp_ar.size() == 0) fail("ar unexpected");
        else begin
          ma = exp_ar.pop_front();
          chk("ar fields", CW'({araddr, arlen, arid, arsize, arburst, arlock, arcache, arprot}),
              CW'({ma.addr, ma.len, ma.id, 3'd4, 2'b01, 1'b0, 4'd0, 3'd0}));
        end
      end
      if (wvalid && wready) begin
        if (exp_w.size() == 0) fail("w unexpected");
        else begin
          mw = exp_w.pop_front();
          chk("wdata", CW'(wdata), CW'(mw.data));
          chk("wlast/wstrb", CW'({wlast, wstrb}), CW'({mw.last, 16'hFFFF}));
        end
      end
      if (done) begin
        if (exp_d.size() == 0) fail("done unexpected");
        else begin
          md = exp_d.pop_front();
          chk("done_err/err_count", CW'({done_err, err_count}), CW'({md.err, md.cnt}));
        end
      end
    end
  end

  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [7:0] l, input logic [IW-1:0] id);
    int t = 0;
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) fail("cmd_ready timeout");
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_len = l; cmd_id = id;
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic slv_write(input int st, input logic [1:0] resp, input logic idflip);
    int t; logic [AW-1:0] a, wa; logic [7:0] l; logic [IW-1:0] id; logic [DW-1:0] d0;
    t = 0; while (!awvalid && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin fail("awvalid timeout"); return; end
    a = awaddr; l = awlen; id = awid;
    repeat (st) begin
      @(negedge clk);
      chk("aw hold", CW'({awvalid, awaddr, awlen}), CW'({1'b1, a, l}));
    end
    awready = 1; @(negedge clk); awready = 0;
    for (int k = 0; k <= int'(l); k++) begin
      t = 0; while (!wvalid && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) begin fail("wvalid timeout"); return; end
      d0 = wdata;
      repeat (st) begin
        @(negedge clk);
        chk("w hold", CW'({wvalid, wdata}), CW'({1'b1, d0}));
      end
      wa = a + AW'(k*SW);
      mem[wa[AW-1:4]] = wdata;
      wready = 1; @(negedge clk); wready = 0;
    end
    bvalid = 1; bresp = resp; bid = id ^ idflip;
    t = 0; while (!bready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) fail("bready timeout");
    @(negedge clk); bvalid = 0; bresp = 0;
  endtask

  task automatic slv_read(input int st, input logic [1:0] resp, input logic idflip, input int last_at);
    int t; logic [AW-1:0] a, ra; logic [7:0] l; logic [IW-1:0] id;
    t = 0; while (!arvalid && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin fail("arvalid timeout"); return; end
    a = araddr; l = arlen; id = arid;
    repeat (st) begin
      @(negedge clk);
      chk("ar hold", CW'({arvalid, araddr, arlen}), CW'({1'b1, a, l}));
    end
    arready = 1; @(negedge clk); arready = 0;
    for (int k = 0; k <= last_at; k++) begin
      repeat (st) @(negedge clk);
      ra = a + AW'(k*SW);
      rvalid = 1; rdata = mem[ra[AW-1:4]]; rresp = resp; rid = id ^ idflip; rlast = (k == last_at);
      t = 0; while (!rready && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) begin fail("rready timeout"); rvalid = 0; return; end
      @(negedge clk); rvalid = 0; rlast = 0; rresp = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, dn;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("reset outputs", CW'({awvalid, arvalid, wvalid, bready, rready, done, done_err, cmd_ready, err_count}),
        CW'({7'b0, 1'b1, 16'h0}));
    rst_n = 1;
    @(negedge clk);

    // write 0x040 len 3 id 1, hand-computed beat data
    exp_aw.push_back('{12'h040, 8'd3, 1'b1});
    exp_w.push_back('{{4{32'hA5A50040}}, 1'b0});
    exp_w.push_back('{{4{32'hA5A50050}}, 1'b0});
    exp_w.push_back('{{4{32'hA5A50060}}, 1'b0});
    exp_w.push_back('{{4{32'hA5A50070}}, 1'b1});
    exp_d.push_back('{1'b0, ecnt});
    issue(1, 12'h040, 8'd3, 1'b1);
    slv_write(0, 2'b00, 1'b0);

    // read it back clean
    exp_ar.push_back('{12'h040, 8'd3, 1'b1});
    exp_d.push_back('{1'b0, ecnt});
    issue(0, 12'h040, 8'd3, 1'b1);
    slv_read(0, 2'b00, 1'b0, 3);
    chk("ram beat 3 content", CW'(mem[8'h07]), CW'({4{32'hA5A50070}}));

    // slave stalls 5 cycles on every channel
    exp_aw.push_back('{12'h100, 8'd2, 1'b0});
    push_w(12'h100, 2);
    exp_d.push_back('{1'b0, ecnt});
    issue(1, 12'h100, 8'd2, 1'b0);
    slv_write(5, 2'b00, 1'b0);
    exp_ar.push_back('{12'h100, 8'd2, 1'b0});
    exp_d.push_back('{1'b0, ecnt});
    issue(0, 12'h100, 8'd2, 1'b0);
    slv_read(5, 2'b00, 1'b0, 2);

    // address wrap at top of space; low bits of cmd_addr ignored
    exp_aw.push_back('{12'hFF0, 8'd1, 1'b0});
    exp_w.push_back('{{4{32'hA5A50FF0}}, 1'b0});
    exp_w.push_back('{{4{32'hA5A50000}}, 1'b1});
    exp_d.push_back('{1'b0, ecnt});
    issue(1, 12'hFF7, 8'd1, 1'b0);
    slv_write(0, 2'b00, 1'b0);

    // bad bresp, then bid mismatch
    exp_aw.push_back('{12'h200, 8'd0, 1'b0});
    push_w(12'h200, 0);
    exp_d.push_back('{1'b1, ecnt});
    issue(1, 12'h200, 8'd0, 1'b0);
    slv_write(0, 2'b10, 1'b0);
    exp_aw.push_back('{12'h210, 8'd0, 1'b1});
    push_w(12'h210, 0);
    exp_d.push_back('{1'b1, ecnt});
    issue(1, 12'h210, 8'd0, 1'b1);
    slv_write(1, 2'b00, 1'b1);

    // corrupt one word at 0x040 and read one beat
    mem[8'h04][0] = ~mem[8'h04][0];
`ifdef AXI_TGEN_RDATA_CHECK_EN
    ecnt = 16'd1;
    exp_d.push_back('{1'b1, ecnt});
`else
    exp_d.push_back('{1'b0, ecnt});
`endif
    exp_ar.push_back('{12'h040, 8'd0, 1'b0});
    issue(0, 12'h040, 8'd0, 1'b0);
    slv_read(0, 2'b00, 1'b0, 0);

    // rresp error, rid mismatch, early rlast
    exp_ar.push_back('{12'h050, 8'd0, 1'b0});
    exp_d.push_back('{1'b1, ecnt});
    issue(0, 12'h050, 8'd0, 1'b0);
    slv_read(0, 2'b10, 1'b0, 0);
    exp_ar.push_back('{12'h060, 8'd1, 1'b1});
    exp_d.push_back('{1'b1, ecnt});
    issue(0, 12'h060, 8'd1, 1'b1);
    slv_read(0, 2'b00, 1'b1, 1);
    exp_ar.push_back('{12'h100, 8'd3, 1'b0});
    exp_d.push_back('{1'b1, ecnt});
    issue(0, 12'h100, 8'd3, 1'b0);
    slv_read(0, 2'b00, 1'b0, 1);

    // reset in the middle of a write burst
    exp_aw.push_back('{12'h300, 8'd7, 1'b0});
    issue(1, 12'h300, 8'd7, 1'b0);
    t = 0; while (!awvalid && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) fail("awvalid timeout before reset");
    awready = 1; @(negedge clk); awready = 0;
    @(negedge clk);
    chk("wvalid up before reset", CW'(wvalid), CW'(1));
    rst_n = 0;
    #1;
    chk("async reset drops valids", CW'({wvalid, awvalid, bready, done, cmd_ready}), CW'(5'b00001));
    repeat (3) @(negedge clk);
    rst_n = 1;
    dn = 0;
    repeat (10) begin @(negedge clk); #1; dn += int'(done); end
    chk("post-reset idle", CW'({cmd_ready, err_count}), CW'({1'b1, 16'h0}));
    chk("no done after reset", CW'(dn), CW'(0));

    chk("scoreboard drained", CW'(exp_aw.size() + exp_ar.size() + exp_w.size() + exp_d.size()), CW'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
